// File: rtl/ps2_kbd_pkg.sv
// ============================================================================
// ps2_kbd_pkg: shared parser states, scan-code-set-2 byte constants, event type
// Rev 1.0
// ============================================================================
`default_nettype none

package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_E0    = 3'd2,
        S_F0    = 3'd3,
        S_E0F0  = 3'd4,
        S_PAUSE = 3'd5
    } parse_state_t;

    localparam logic [7:0] BAT_OK     = 8'hAA;
    localparam logic [7:0] BAT_FAIL   = 8'hFC;
    localparam logic [7:0] EXT        = 8'hE0;
    localparam logic [7:0] BRK        = 8'hF0;
    localparam logic [7:0] PAUSE_PFX  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       is_break;
        logic       extend;
        logic [7:0] code;
    } kbd_evt_t;

    localparam int EVT_W = $bits(kbd_evt_t);

endpackage

`default_nettype wire

// File: rtl/ps2_evt_sync_fifo.sv
// ============================================================================
// ps2_evt_sync_fifo: show-ahead synchronous FIFO with occupancy/full/empty
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_evt_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign w_wr  = push && (!full || pop);
    assign w_rd  = pop && !empty;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_event_fifo.sv
// ============================================================================
// ps2_key_event_fifo: PS/2 set-2 decoder with held-key map and queued events.
// Optional KBD_EVT_TIMESTAMP_EN adds a cycle/1024 stamp per event. Rev 1.0
// ============================================================================
`default_nettype none

module ps2_key_event_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 8,
    parameter int         FILTER_REPEAT = 1,
    parameter int         TIMEOUT_CYC   = 2_000_000,
    parameter logic [8:0] PAUSE_CODE    = 9'h1E1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          rx_err,
    output logic                          kbd_ready,
    output logic [511:0]                  key_down,
    output logic [8:0]                    last_change,
    output logic                          key_valid,
    output logic [8:0]                    evt_code,
    output logic                          evt_break,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          ovf,
    input  logic                          ovf_clr
`ifdef KBD_EVT_TIMESTAMP_EN
    ,
    output logic [15:0]                   evt_time
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYC);
`ifdef KBD_EVT_TIMESTAMP_EN
    localparam int FW = EVT_W + 16;
`else
    localparam int FW = EVT_W;
`endif

    parse_state_t r_state, w_state_nxt;
    logic [2:0]    r_skip, w_skip_nxt;
    logic [TW-1:0] r_to_cnt;
    logic          w_prefix, w_timeout;
    logic          w_fire, w_set_rdy, w_clr_rdy, w_clr_map;
    kbd_evt_t      w_evt, w_head;
    logic [8:0]    w_idx;
    logic          w_push, w_pop, w_drop, w_full, w_empty;
    logic [FW-1:0] w_wdata, w_rdata;

    assign w_prefix  = (r_state == S_E0) || (r_state == S_F0) ||
                       (r_state == S_E0F0) || (r_state == S_PAUSE);
    assign w_timeout = w_prefix && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_INIT;
            r_skip   <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
            if (!w_prefix || rx_valid || rx_err || w_timeout) r_to_cnt <= '0;
            else                                              r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_fire      = 1'b0;
        w_evt       = '0;
        w_set_rdy   = 1'b0;
        w_clr_rdy   = 1'b0;
        w_clr_map   = 1'b0;
        if (rx_err && r_state != S_INIT) begin
            w_state_nxt = S_IDLE;
        end else if (rx_valid) begin
            case (r_state)
                S_INIT: begin
                    if (rx_data == BAT_OK) begin
                        w_state_nxt = S_IDLE;
                        w_set_rdy   = 1'b1;
                    end
                end
                S_IDLE: begin
                    case (rx_data)
                        EXT:       w_state_nxt = S_E0;
                        BRK:       w_state_nxt = S_F0;
                        PAUSE_PFX: begin
                            w_state_nxt = S_PAUSE;
                            w_skip_nxt  = PAUSE_SKIP;
                        end
                        BAT_OK:    w_clr_map = 1'b1;
                        BAT_FAIL: begin
                            w_state_nxt = S_INIT;
                            w_clr_rdy   = 1'b1;
                        end
                        default: begin
                            w_fire      = 1'b1;
                            w_evt.code  = rx_data;
                        end
                    endcase
                end
                S_E0: begin
                    if (rx_data == BRK) begin
                        w_state_nxt = S_E0F0;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_fire       = 1'b1;
                        w_evt.extend = 1'b1;
                        w_evt.code   = rx_data;
                    end
                end
                S_F0, S_E0F0: begin
                    w_state_nxt    = S_IDLE;
                    w_fire         = 1'b1;
                    w_evt.is_break = 1'b1;
                    w_evt.extend   = (r_state == S_E0F0);
                    w_evt.code     = rx_data;
                end
                S_PAUSE: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_state_nxt  = S_IDLE;
                        w_fire       = 1'b1;
                        w_evt.extend = PAUSE_CODE[8];
                        w_evt.code   = PAUSE_CODE[7:0];
                    end
                end
                default: w_state_nxt = S_INIT;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign w_idx  = {w_evt.extend, w_evt.code};
    // Typematic repeats only re-pulse key_valid; breaks always reach the queue.
    assign w_push = w_fire && !(!w_evt.is_break && (FILTER_REPEAT != 0) && key_down[w_idx]);
    assign w_pop  = evt_ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_ready   <= 1'b0;
            key_down    <= '0;
            last_change <= '0;
            key_valid   <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            key_valid <= w_fire;
            if (w_fire) last_change <= w_idx;
            if (w_set_rdy)      kbd_ready <= 1'b1;
            else if (w_clr_rdy) kbd_ready <= 1'b0;
            if (w_clr_map) begin
                key_down <= '0;
            end else if (w_fire) begin
                if (w_evt.is_break)          key_down[w_idx] <= 1'b0;
                else if (w_idx != PAUSE_CODE) key_down[w_idx] <= 1'b1;
            end
            if (w_drop)       ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

`ifdef KBD_EVT_TIMESTAMP_EN
    logic [9:0]  r_presc;
    logic [15:0] r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= '0;
        end else begin
            r_presc <= r_presc + 10'd1;
            if (r_presc == 10'h3FF) r_tick <= r_tick + 16'd1;
        end
    end

    assign w_wdata  = {r_tick, w_evt};
    assign evt_time = w_empty ? 16'd0 : w_rdata[FW-1 -: 16];
`else
    assign w_wdata  = w_evt;
`endif

    ps2_evt_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .count (evt_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Head fields read as zero while empty so nothing stale leaks out after reset.
    assign w_head    = kbd_evt_t'(w_rdata[EVT_W-1:0]);
    assign evt_valid = !w_empty;
    assign evt_code  = w_empty ? 9'd0 : {w_head.extend, w_head.code};
    assign evt_break = !w_empty && w_head.is_break;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_event_fifo.sv
// ============================================================================
// tb_ps2_key_event_fifo: directed + random stimulus against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_key_event_fifo;

    localparam int DEPTH  = 8;
    localparam int FILT   = 1;
    localparam int TOUT   = 32;
    localparam logic [8:0] PCODE = 9'h1E1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_err = 1'b0;
    logic         evt_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic         kbd_ready, key_valid, evt_break, evt_valid, ovf;
    logic [511:0] key_down;
    logic [8:0]   last_change, evt_code;
    logic [3:0]   evt_count;
`ifdef KBD_EVT_TIMESTAMP_EN
    logic [15:0]  evt_time;
`endif

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    ps2_key_event_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .FILTER_REPEAT (FILT),
        .TIMEOUT_CYC   (TOUT),
        .PAUSE_CODE    (PCODE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .kbd_ready   (kbd_ready),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .evt_code    (evt_code),
        .evt_break   (evt_break),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_count   (evt_count),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
`ifdef KBD_EVT_TIMESTAMP_EN
        ,
        .evt_time    (evt_time)
`endif
    );

    // Reference model: prefix flags, a held-key bitmap and a bounded queue.
    bit           m_ready = 0;
    bit           m_ext = 0;
    bit           m_brk = 0;
    int           m_pause_left = 0;
    int           m_idle = 0;
    bit [511:0]   m_map = '0;
    bit [8:0]     m_last = '0;
    bit           m_kv = 0;
    bit           m_ovf = 0;
    logic [9:0]   m_q[$];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit       fire = 0;
        bit       brk = 0;
        bit [8:0] code = '0;
        bit       do_pop;
        bit       do_push = 0;
        do_pop = evt_ready && (m_q.size() > 0);
        m_kv = 0;
        if (!m_ready) begin
            if (rx_valid && rx_data == 8'hAA) m_ready = 1;
        end else if (rx_err) begin
            m_ext = 0; m_brk = 0; m_pause_left = 0; m_idle = 0;
        end else if (rx_valid) begin
            m_idle = 0;
            if (m_pause_left > 0) begin
                m_pause_left--;
                if (m_pause_left == 0) begin fire = 1; code = PCODE; end
            end else if (rx_data == 8'hF0 && !m_brk) m_brk = 1;
            else if (rx_data == 8'hE0 && !m_ext && !m_brk) m_ext = 1;
            else if (!m_ext && !m_brk && rx_data == 8'hE1) m_pause_left = 7;
            else if (!m_ext && !m_brk && rx_data == 8'hAA) m_map = '0;
            else if (!m_ext && !m_brk && rx_data == 8'hFC) m_ready = 0;
            else begin
                fire = 1; brk = m_brk; code = {m_ext, rx_data};
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk || m_pause_left > 0) begin
            m_idle++;
            if (m_idle == TOUT) begin
                m_ext = 0; m_brk = 0; m_pause_left = 0; m_idle = 0;
            end
        end
        if (fire) begin
            m_kv = 1;
            m_last = code;
            if (brk) begin
                m_map[code] = 0;
                do_push = 1;
            end else begin
                do_push = !(FILT != 0 && m_map[code]);
                if (code != PCODE) m_map[code] = 1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back({brk, code});
            else m_ovf = 1;
        end
        if (!(do_push && m_q.size() >= DEPTH && !do_pop) && ovf_clr && !(do_push && !do_pop && m_q.size() == DEPTH && m_ovf))
            m_ovf = m_ovf;
        if (ovf_clr && !(do_push && !do_pop && fire && m_q.size() == DEPTH && m_q[$] != {brk, code}))
            m_ovf = m_ovf;
    endtask

    // Overflow stickiness is resolved separately so set wins over clear.
    bit m_drop_now;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_ext = 0; m_brk = 0; m_pause_left = 0; m_idle = 0;
            m_map = '0; m_last = '0; m_kv = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            bit clr_req;
            bit ovf_before;
            clr_req = ovf_clr;
            ovf_before = m_ovf;
            m_ovf = 0;
            model_step();
            m_drop_now = m_ovf;
            m_ovf = m_drop_now ? 1'b1 : (clr_req ? 1'b0 : ovf_before);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("kbd_ready", kbd_ready, m_ready);
            chk("key_down", key_down, m_map);
            chk("key_valid", key_valid, m_kv);
            chk("last_change", last_change, m_last);
            chk("evt_valid", evt_valid, m_q.size() != 0);
            chk("evt_count", evt_count, m_q.size());
            chk("ovf", ovf, m_ovf);
            if (m_q.size() != 0) begin
                chk("evt_code", evt_code, m_q[0][8:0]);
                chk("evt_break", evt_break, m_q[0][9]);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drain();
        @(negedge clk); #1;
        evt_ready = 1'b1;
        idle(DEPTH + 2);
        evt_ready = 1'b0;
    endtask

    initial begin
        idle(3);
        chk("rst_kbd_ready", kbd_ready, 0);
        chk("rst_key_down", key_down, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_count", evt_count, 0);
        chk("rst_ovf", ovf, 0);
        started = 1'b1;
        rst_n = 1'b1;

        send(8'hAA);
        chk("bat_ready", kbd_ready, 1);
        chk("bat_no_evt", evt_valid, 0);
        send(8'h1D);
        chk("make1d_map", key_down[9'h01D], 1);
        chk("make1d_kv", key_valid, 1);
        chk("make1d_code", evt_code, 9'h01D);
        chk("make1d_brk", evt_break, 0);
        chk("make1d_cnt", evt_count, 1);
        send(8'hF0); send(8'h1D);
        drain();

        send(8'hE0); send(8'h75);
        chk("e075_map", key_down[9'h175], 1);
        chk("e075_code", evt_code, 9'h175);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("e0f075_map", key_down[9'h175], 0);
        chk("e0f075_last", last_change, 9'h175);
        chk("e0f075_cnt", evt_count, 2);
        drain();

        for (int i = 0; i < 3; i++) begin
            send(8'h1C);
            chk("rep_kv", key_valid, 1);
        end
        chk("rep_cnt", evt_count, 1);
        drain();

        for (int i = 0; i < 9; i++) send(8'h21 + 8'(i));
        chk("ovf_cnt", evt_count, 8);
        chk("ovf_set", ovf, 1);
        chk("ovf_ninth_held", key_down[9'h029], 1);
        @(negedge clk); #1; ovf_clr = 1'b1;
        @(negedge clk); #1; ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        @(negedge clk); #1; rx_data = 8'h2A; rx_valid = 1'b1; evt_ready = 1'b1;
        @(negedge clk); #1; rx_valid = 1'b0; evt_ready = 1'b0;
        chk("full_pushpop_cnt", evt_count, 8);
        chk("full_pushpop_ovf", ovf, 0);
        chk("full_pushpop_head", evt_code, 9'h022);
        drain();

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_cnt", evt_count, 1);
        chk("pause_code", evt_code, 9'h1E1);
        chk("pause_unheld", key_down[9'h1E1], 0);
        chk("pause_14_unheld", key_down[9'h014], 0);
        drain();

        send(8'hF0);
        idle(TOUT + 5);
        send(8'h1D);
        chk("tout_make", evt_break, 0);
        chk("tout_code", evt_code, 9'h01D);
        chk("tout_held", key_down[9'h01D], 1);
        drain();

        send(8'hE0);
        @(negedge clk); #1; rx_err = 1'b1;
        @(negedge clk); #1; rx_err = 1'b0;
        send(8'h6B);
        chk("err_code", evt_code, 9'h06B);
        drain();

        send(8'hFC);
        chk("fc_ready", kbd_ready, 0);
        send(8'h33);
        chk("fc_ignored", evt_valid, 0);
        send(8'hAA);
        chk("fc_rebat", kbd_ready, 1);

        send(8'h3C); send(8'hE0);
        @(negedge clk); #1; rst_n = 1'b0;
        #1;
        chk("midrst_map", key_down, 0);
        chk("midrst_ready", kbd_ready, 0);
        chk("midrst_valid", evt_valid, 0);
        chk("midrst_last", last_change, 0);
        @(negedge clk); #1; rst_n = 1'b1;
        send(8'hAA);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk); #1;
            rx_valid  = ($urandom_range(0, 99) < 45);
            rx_err    = ($urandom_range(0, 99) < 2);
            ovf_clr   = ($urandom_range(0, 99) < 4);
            evt_ready = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 99) < 60)
                                               : ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 99)) inside
                [0:59]:  rx_data = 8'h10 + 8'($urandom_range(0, 11));
                [60:71]: rx_data = 8'hE0;
                [72:85]: rx_data = 8'hF0;
                [86:90]: rx_data = 8'hE1;
                [91:93]: rx_data = 8'hAA;
                94:      rx_data = 8'hFC;
                default: rx_data = 8'($urandom_range(0, 255));
            endcase
            if (cyc % 500 == 250) begin
                rx_valid = 1'b0; rx_err = 1'b0;
                idle(TOUT + 3);
            end
        end
        rx_valid = 1'b0; rx_err = 1'b0; ovf_clr = 1'b0; evt_ready = 1'b0;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
